uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
//
// PURPOSE
//   Receive-side word buffer directly downstream of the UART receiver.
//   - Captures each completed word on the receiver's ready strobe.
//   - Stores up to DEPTH words; presents them first-word-fall-through on a
//     valid/ready stream.
//   - Drives flow control back to the receiver so it will not start a new
//     frame unless there is space for it.
//
// PARAMETERS
//   WIDTH                 8   word width; equals the receiver's width
//   DEPTH                 16  entries; power of two, >= 2
//   ALMOST_FULL_HEADROOM  2   free entries reserved when UART_RX_FIFO_ALMOST_FULL_EN
//                             is set; 1 <= value < DEPTH
//
// PORTS
//   clock          in   1                    system clock, all logic on posedge
//   resetn         in   1                    synchronous reset, active-low
//   rx_data        in   WIDTH                word from receiver; valid while rx_ready=1
//   rx_ready       in   1                    receiver word-complete level; may stay high many cycles
//   rx_can_receive out  1                    to receiver can_receive_next_word
//   out_data       out  WIDTH                head-of-queue word (FWFT)
//   out_valid      out  1                    queue non-empty
//   out_ready      in   1                    consumer accepts head this cycle
//   count          out  $clog2(DEPTH)+1      words currently stored
//   overflow       out  1                    1-cycle pulse: word dropped because full
//
// BEHAVIOUR
//   - Reset (resetn=0 at posedge):
//     - rd_ptr, wr_ptr and count go to 0; rx_ready_q goes to 0.
//     - Outputs: out_valid=0, overflow=0, rx_can_receive=1.
//     - Reset mid-operation discards all contents; memory is not cleared.
//   - Push detect:
//     - push = rx_ready & ~rx_ready_q, with rx_ready_q registered every cycle.
//     - Exactly one push per receiver word, however long rx_ready stays high.
//     - rx_data is sampled in the push cycle.
//   - Pop: pop = out_valid & out_ready.
//   - out_valid = (count != 0).
//   - out_data = mem[rd_ptr] (combinational read); X when empty.
//   - Latency: a word pushed at edge N gives out_valid=1 after edge N; zero
//     extra cycles.
//   - Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH naturally.
//     count: +1 on push only, -1 on pop only, unchanged when both.
//   - Full (count==DEPTH):
//     - push without pop: word dropped, overflow=1 for one cycle, no state change.
//     - push with pop: both accepted, count stays DEPTH.
//   - Empty: pop cannot occur (out_valid=0); a push and out_ready=1 in the
//     same cycle only stores the word.
//   - rx_can_receive = (count < DEPTH), combinational from count.
//   - overflow is registered: high the cycle after the dropped push, else 0.
//   - No other state machine; storage is an array of DEPTH x WIDTH flops.
//
// CONFIGURATION
//   UART_RX_FIFO_ALMOST_FULL_EN
//     defined:   rx_can_receive = (count < DEPTH - ALMOST_FULL_HEADROOM); adds
//                output almost_full = ~rx_can_receive. Gives slack for a word
//                already in flight when the threshold is reached.
//     undefined: rx_can_receive = (count < DEPTH); no almost_full port;
//                ALMOST_FULL_HEADROOM is ignored.
//
// TESTING
//   1. Reset: hold resetn=0 for 3 cycles -> count=0, out_valid=0,
//      rx_can_receive=1, overflow=0.
//   2. rx_data=8'hA5, rx_ready high for 10 cycles, out_ready=0 ->
//      count=1 after the first edge only; out_data=8'hA5.
//   3. Push 8'h00..8'h0F (DEPTH=16), then drain with out_ready=1 ->
//      words appear in order; count=16 and rx_can_receive=0 at full;
//      pointers wrap, proven by a second 16-word pass.
//   4. Full, then push 8'hFF with out_ready=0 -> overflow pulses 1 cycle;
//      count stays 16; 8'hFF is never output.
//   5. Full, then push 8'h77 with out_ready=1 in the same cycle -> head
//      popped; count stays 16; 8'h77 is output last.
//   6. ALMOST_FULL_EN, DEPTH=16, HEADROOM=2 -> rx_can_receive drops at
//      count=14; reset asserted at count=5 -> count=0 and out_valid=0 next cycle.

Source files
------------

// File: rtl/uart_rx_fifo_if.sv
// Receiver-to-FIFO-to-consumer signal bundle. When UART_RX_FIFO_ALMOST_FULL_EN
// is defined, the bundle also carries almost_full.
interface uart_rx_fifo_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] rx_data;
  logic             rx_ready;
  logic             rx_can_receive;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    count;
  logic             overflow;
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
  logic             almost_full;

  modport slave  (input  rx_data, rx_ready, out_ready,
                  output rx_can_receive, out_data, out_valid, count, overflow, almost_full);
  modport master (output rx_data, rx_ready, out_ready,
                  input  rx_can_receive, out_data, out_valid, count, overflow, almost_full);
`else
  modport slave  (input  rx_data, rx_ready, out_ready,
                  output rx_can_receive, out_data, out_valid, count, overflow);
  modport master (output rx_data, rx_ready, out_ready,
                  input  rx_can_receive, out_data, out_valid, count, overflow);
`endif
endinterface

// File: rtl/uart_rx_fifo.sv
// FWFT receive buffer behind the UART receiver, with flow control back to it.
// UART_RX_FIFO_ALMOST_FULL_EN lowers rx_can_receive by a headroom margin and adds almost_full.
module uart_rx_fifo #(
  parameter int WIDTH                = 8,
  parameter int DEPTH                = 16,
  parameter int ALMOST_FULL_HEADROOM = 2
) (
  input  logic           clock,
  input  logic           resetn,
  uart_rx_fifo_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
  localparam logic [CW-1:0] RECV_LIM = CW'(DEPTH - ALMOST_FULL_HEADROOM);
`else
  localparam logic [CW-1:0] RECV_LIM = FULL_CNT;
`endif

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             rx_ready_q, overflow_q, overflow_d;
  logic             push, pop, full, wr_en;

  // Edge-detect so a level that stays high still yields a single push.
  assign push  = bus.rx_ready & ~rx_ready_q;
  assign full  = (count_q == FULL_CNT);
  assign pop   = (count_q != '0) & bus.out_ready;
  assign wr_en = push & (~full | pop);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = push & full & ~pop;
    if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)   rd_ptr_d = rd_ptr_q + PW'(1);
    if (wr_en && !pop)      count_d = count_q + CW'(1);
    else if (pop && !wr_en) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rx_ready_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rx_ready_q <= bus.rx_ready;
      overflow_q <= overflow_d;
    end
  end

  // Storage is deliberately left uncleared by reset.
  always_ff @(posedge clock) begin
    if (resetn && wr_en) mem_q[wr_ptr_q] <= bus.rx_data;
  end

  assign bus.out_data       = mem_q[rd_ptr_q];
  assign bus.out_valid      = (count_q != '0);
  assign bus.count          = count_q;
  assign bus.overflow       = overflow_q;
  assign bus.rx_can_receive = (count_q < RECV_LIM);
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
  assign bus.almost_full    = ~bus.rx_can_receive;
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo (WIDTH=8, DEPTH=16); honours UART_RX_FIFO_ALMOST_FULL_EN.
module tb_uart_rx_fifo;
  localparam int DEPTH = 16;
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
  localparam int THR = DEPTH - 2;
`else
  localparam int THR = DEPTH;
`endif

  logic clock = 1'b0;
  logic resetn = 1'b0;
  int   vectors = 0;
  int   errors  = 0;

  uart_rx_fifo_if #(.WIDTH(8), .DEPTH(DEPTH)) bus ();
  uart_rx_fifo #(.WIDTH(8), .DEPTH(DEPTH), .ALMOST_FULL_HEADROOM(2)) dut (
    .clock(clock), .resetn(resetn), .bus(bus));

  always #5 clock = ~clock;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic push_word(input logic [7:0] d, input logic ordy);
    bus.rx_data = d; bus.rx_ready = 1'b1; bus.out_ready = ordy;
    @(negedge clock);
    bus.rx_ready = 1'b0; bus.out_ready = 1'b0;
    @(negedge clock);
  endtask

  task automatic pop_word();
    bus.out_ready = 1'b1;
    @(negedge clock);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clock);
    vectors++;
    if (bus.count !== 5'd0 || bus.out_valid !== 1'b0 || bus.rx_can_receive !== 1'b1 || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset: count=%0d valid=%b can=%b ovf=%b, want 0 0 1 0",
               bus.count, bus.out_valid, bus.rx_can_receive, bus.overflow);
    end
    resetn = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_level_push();
    bus.rx_data = 8'hA5; bus.rx_ready = 1'b1; bus.out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      vectors++;
      if (bus.count !== 5'd1) begin
        errors++;
        $display("FAIL level_push cycle %0d: count=%0d, want 1", i, bus.count);
      end
    end
    bus.rx_ready = 1'b0;
    bus.rx_data = 8'h00;
    @(negedge clock);
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hA5) begin
      errors++;
      $display("FAIL level_data: valid=%b data=%h, want 1 a5", bus.out_valid, bus.out_data);
    end
    pop_word();
    vectors++;
    if (bus.count !== 5'd0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL level_drain: count=%0d valid=%b, want 0 0", bus.count, bus.out_valid);
    end
  endtask

  task automatic test_order(input logic [7:0] base);
    for (int i = 0; i < DEPTH; i++) begin
      push_word(base + 8'(i), 1'b0);
      vectors++;
      if (bus.count !== 5'(i + 1) || bus.rx_can_receive !== ((i + 1) < THR)) begin
        errors++;
        $display("FAIL fill %h #%0d: count=%0d can=%b, want %0d %b",
                 base, i, bus.count, bus.rx_can_receive, i + 1, ((i + 1) < THR));
      end
    end
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
    vectors++;
    if (bus.almost_full !== 1'b1) begin
      errors++;
      $display("FAIL almost_full at full: got %b want 1", bus.almost_full);
    end
`endif
    for (int i = 0; i < DEPTH; i++) begin
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== base + 8'(i)) begin
        errors++;
        $display("FAIL drain %h #%0d: valid=%b data=%h, want 1 %h",
                 base, i, bus.out_valid, bus.out_data, base + 8'(i));
      end
      pop_word();
    end
    vectors++;
    if (bus.count !== 5'd0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drained %h: count=%0d valid=%b, want 0 0", base, bus.count, bus.out_valid);
    end
  endtask

  task automatic test_overflow_and_full_pushpop();
    for (int i = 0; i < DEPTH; i++) push_word(8'h20 + 8'(i), 1'b0);
    bus.rx_data = 8'hFF; bus.rx_ready = 1'b1; bus.out_ready = 1'b0;
    @(negedge clock);
    bus.rx_ready = 1'b0;
    vectors++;
    if (bus.overflow !== 1'b1 || bus.count !== 5'd16) begin
      errors++;
      $display("FAIL overflow pulse: ovf=%b count=%0d, want 1 16", bus.overflow, bus.count);
    end
    @(negedge clock);
    vectors++;
    if (bus.overflow !== 1'b0 || bus.out_data !== 8'h20) begin
      errors++;
      $display("FAIL overflow end: ovf=%b head=%h, want 0 20", bus.overflow, bus.out_data);
    end
    push_word(8'h77, 1'b1);
    vectors++;
    if (bus.count !== 5'd16 || bus.overflow !== 1'b0 || bus.out_data !== 8'h21) begin
      errors++;
      $display("FAIL full push+pop: count=%0d ovf=%b head=%h, want 16 0 21",
               bus.count, bus.overflow, bus.out_data);
    end
    for (int i = 1; i <= DEPTH; i++) begin
      vectors++;
      if (bus.out_data !== ((i == DEPTH) ? 8'h77 : 8'h20 + 8'(i))) begin
        errors++;
        $display("FAIL full drain #%0d: data=%h, want %h",
                 i, bus.out_data, (i == DEPTH) ? 8'h77 : 8'h20 + 8'(i));
      end
      pop_word();
    end
    vectors++;
    if (bus.count !== 5'd0) begin
      errors++;
      $display("FAIL full drain end: count=%0d, want 0", bus.count);
    end
  endtask

  task automatic test_empty_push_pop();
    push_word(8'h3C, 1'b1);
    vectors++;
    if (bus.count !== 5'd1 || bus.out_data !== 8'h3C) begin
      errors++;
      $display("FAIL empty push+ready: count=%0d data=%h, want 1 3c", bus.count, bus.out_data);
    end
    pop_word();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) push_word(8'h50 + 8'(i), 1'b0);
    vectors++;
    if (bus.count !== 5'd5) begin
      errors++;
      $display("FAIL mid fill: count=%0d, want 5", bus.count);
    end
    resetn = 1'b0;
    @(negedge clock);
    vectors++;
    if (bus.count !== 5'd0 || bus.out_valid !== 1'b0 || bus.rx_can_receive !== 1'b1) begin
      errors++;
      $display("FAIL mid reset: count=%0d valid=%b can=%b, want 0 0 1",
               bus.count, bus.out_valid, bus.rx_can_receive);
    end
    resetn = 1'b1;
    @(negedge clock);
  endtask

  initial begin
    bus.rx_data = 8'h00; bus.rx_ready = 1'b0; bus.out_ready = 1'b0;
    @(negedge clock);
    test_reset();
    test_level_push();
    test_order(8'h00);
    test_order(8'h40);
    test_overflow_and_full_pushpop();
    test_empty_push_pop();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
